// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter slice.
package bcd_pkg;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_ZERO = 4'd0;

  function automatic logic is_bcd_valid(input logic [BCD_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: load, increment/decrement with wrap, terminal-value flag.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             up_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] q_o,
  output logic             tc_o
);

  logic [BCD_W-1:0] q_q, q_d;

  // tc is the exact terminal digit (9 up, 0 down), used for CARRY_OUT and saturation
  assign tc_o = up_i ? (q_q == BCD_MAX) : (q_q == BCD_ZERO);
  assign q_o  = q_q;

  // Out-of-range nibbles behave like 9 when counting up and decrement plainly when counting down
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        q_d = (q_q >= BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) q_q <= BCD_ZERO;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, wrap/saturate and cascade flag.
// Define BCD_COUNTER_LOAD_CHECK_EN to clamp non-BCD load nibbles and add load_err_o.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  carry_out_o,
`ifdef BCD_COUNTER_LOAD_CHECK_EN
  output logic                  load_err_o,
`endif
  output logic                  zero_o
);

  logic [DIGITS-1:0]   en_chain;
  logic [DIGITS-1:0]   tc;
  logic [DIGITS-1:0]   dig_zero;
  logic [4*DIGITS-1:0] load_val;
  logic                all_tc;
  logic                sat_hold;

  assign all_tc      = &tc;
  assign sat_hold    = SATURATE & all_tc;
  assign carry_out_o = enable_i & ~load_i & ~clear_i & all_tc;
  assign zero_o      = &dig_zero;
  assign en_chain[0] = enable_i & ~load_i & ~sat_hold;

`ifdef BCD_COUNTER_LOAD_CHECK_EN
  logic [DIGITS-1:0] nib_bad;
  logic              load_err_q;

  always_comb begin
    load_val = load_value_i;
    nib_bad  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd_valid(load_value_i[4*k +: 4])) begin
        nib_bad[k]        = 1'b1;
        load_val[4*k +: 4] = BCD_MAX;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) load_err_q <= 1'b0;
    else         load_err_q <= load_i & (|nib_bad);
  end

  assign load_err_o = load_err_q;
`else
  assign load_val = load_value_i;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [BCD_W-1:0] q;

    bcd_digit u_digit (
      .clk_i      (clk_i),
      .clr_i      (clear_i),
      .up_i       (up_i),
      .en_i       (en_chain[k]),
      .load_i     (load_i),
      .load_val_i (load_val[4*k +: 4]),
      .q_o        (q),
      .tc_o       (tc[k])
    );

    assign bcd_o[4*k +: 4] = q;
    assign dig_zero[k]     = (q == BCD_ZERO);

    // Ripple uses >=9 going up so an out-of-range digit still carries
    if (k > 0) begin : g_ripple
      assign en_chain[k] = en_chain[k-1] &
                           (up_i ? (g_digit[k-1].q >= BCD_MAX)
                                 : (g_digit[k-1].q == BCD_ZERO));
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: wrap and saturate instances share stimulus, decimal reference model.
module tb_bcd_updown_counter;

  logic        clk;
  logic        clear, enable, up, load;
  logic [15:0] load_value;
  logic [15:0] bcd_w, bcd_s;
  logic        carry_w, carry_s, zero_w, zero_s;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
  logic        err_w, err_s;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_w, exp_s;
  logic [15:0] q_w[$];
  logic [15:0] q_s[$];
  logic        q_err[$];

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .clear_i(clear), .enable_i(enable), .up_i(up), .load_i(load),
    .load_value_i(load_value), .bcd_o(bcd_w), .carry_out_o(carry_w),
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    .load_err_o(err_w),
`endif
    .zero_o(zero_w));

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .clear_i(clear), .enable_i(enable), .up_i(up), .load_i(load),
    .load_value_i(load_value), .bcd_o(bcd_s), .carry_out_o(carry_s),
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    .load_err_o(err_s),
`endif
    .zero_o(zero_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic bit all_valid(input logic [15:0] v);
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int b2i(input logic [15:0] v);
    return v[15:12]*1000 + v[11:8]*100 + v[7:4]*10 + v[3:0];
  endfunction

  function automatic logic [15:0] i2b(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] load_model(input logic [15:0] lv);
    logic [15:0] r;
    r = lv;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    for (int k = 0; k < 4; k++) if (r[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
`endif
    return r;
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] cur, input logic c, l, e, u,
                                             input logic [15:0] lv, input bit sat);
    int v;
    logic [15:0] r;
    logic [3:0] nib;
    bit go;
    if (c) return 16'h0000;
    if (l) return load_model(lv);
    if (!e) return cur;
    if (!all_valid(cur)) begin
      // digit-by-digit only for non-BCD contents: A-F acts as 9 going up, plain decrement going down
      r = cur;
      go = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (go) begin
          nib = r[4*k +: 4];
          if (u) begin
            if (nib >= 4'd9) r[4*k +: 4] = 4'd0;
            else begin r[4*k +: 4] = nib + 4'd1; go = 1'b0; end
          end else begin
            if (nib == 4'd0) r[4*k +: 4] = 4'd9;
            else begin r[4*k +: 4] = nib - 4'd1; go = 1'b0; end
          end
        end
      end
      return r;
    end
    v = b2i(cur);
    if (u) v = (v == 9999) ? (sat ? v : 0) : v + 1;
    else   v = (v == 0) ? (sat ? 0 : 9999) : v - 1;
    return i2b(v);
  endfunction

  task automatic step(input logic c, l, e, u, input logic [15:0] lv);
    logic exp_cw, exp_cs, exp_err;
    logic [15:0] got_w, got_s, want_w, want_s;
    @(negedge clk);
    clear = c; load = l; enable = e; up = u; load_value = lv;
    #1;
    exp_cw = e & ~l & ~c & (u ? (exp_w == 16'h9999) : (exp_w == 16'h0000));
    exp_cs = e & ~l & ~c & (u ? (exp_s == 16'h9999) : (exp_s == 16'h0000));
    vectors++;
    if (carry_w !== exp_cw) begin
      miscompares++;
      $display("FAIL carry_wrap: got %b expected %b (bcd=%h)", carry_w, exp_cw, exp_w);
    end
    vectors++;
    if (carry_s !== exp_cs) begin
      miscompares++;
      $display("FAIL carry_sat: got %b expected %b (bcd=%h)", carry_s, exp_cs, exp_s);
    end
    exp_w = model_next(exp_w, c, l, e, u, lv, 1'b0);
    exp_s = model_next(exp_s, c, l, e, u, lv, 1'b1);
    exp_err = ~c & l & ~all_valid(lv);
    q_w.push_back(exp_w);
    q_s.push_back(exp_s);
    q_err.push_back(exp_err);
    @(posedge clk);
    #1;
    want_w = q_w.pop_front();
    want_s = q_s.pop_front();
    exp_err = q_err.pop_front();
    got_w = bcd_w;
    got_s = bcd_s;
    vectors++;
    if (got_w !== want_w) begin
      miscompares++;
      $display("FAIL bcd_wrap: got %h expected %h", got_w, want_w);
    end
    vectors++;
    if (got_s !== want_s) begin
      miscompares++;
      $display("FAIL bcd_sat: got %h expected %h", got_s, want_s);
    end
    vectors++;
    if (zero_w !== (want_w == 16'h0000)) begin
      miscompares++;
      $display("FAIL zero_wrap: got %b expected %b", zero_w, (want_w == 16'h0000));
    end
    vectors++;
    if (zero_s !== (want_s == 16'h0000)) begin
      miscompares++;
      $display("FAIL zero_sat: got %b expected %b", zero_s, (want_s == 16'h0000));
    end
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    vectors++;
    if (err_w !== exp_err || err_s !== exp_err) begin
      miscompares++;
      $display("FAIL load_err: got %b/%b expected %b", err_w, err_s, exp_err);
    end
`endif
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    vectors++;
    if (bcd_w !== 16'h0012) begin
      miscompares++;
      $display("FAIL count_up_12: got %h expected 0012", bcd_w);
    end
  endtask

  task automatic test_wrap_up();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    // opposite direction leaves the saturated terminal
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_wrap_down();
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic test_priority();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0777);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h4321);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h4321);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_hold_clear();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0450);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    vectors++;
    if (bcd_w !== 16'h0457) begin
      miscompares++;
      $display("FAIL hold_0457: got %h expected 0457", bcd_w);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0099);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0900);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_load_check();
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1A2F);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  initial begin
    clear = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 16'h0000;
    exp_w = 16'h0000;
    exp_s = 16'h0000;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_hold_clear();
    test_back_to_back();
    test_load_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
